// File: rtl/cmd_link.sv
// cmd_link: robot-side end of the remote command link.
// The RX path deserializes 8N1 UART frames. Each pair of bytes is assembled
// into a 16-bit command, and a sticky cmd_rdy flag tells the consumer that a
// command is waiting. The TX path serializes a one-byte response when the
// trmt input is pulsed.
// Optional feature: define CMD_TIMEOUT_EN to abandon a half-received command
// when no low byte arrives within TMO_BITS bit times after the high byte.
module cmd_link #(
    parameter int BAUD_DIV = 2604,
    parameter int TMO_BITS = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);

    localparam int CNT_W = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] BAUD_FULL = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] BAUD_HALF = CNT_W'(BAUD_DIV / 2 - 1);

    typedef enum logic {RX_IDLE, RX_RECV}  rx_state_t;
    typedef enum logic {ASM_HIGH, ASM_LOW} asm_state_t;
    typedef enum logic {TX_IDLE, TX_XMIT}  tx_state_t;

    // ------------------------------------------------------------------
    // RX synchronizer and start-edge detection
    // ------------------------------------------------------------------
    logic r_rxSync1;
    logic r_rxSync2;
    logic r_rxPrev;
    logic w_fallEdge;
    logic w_startDet;

    // Two-flop synchronizer plus one history flop; all preset to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxSync1 <= 1'b1;
            r_rxSync2 <= 1'b1;
            r_rxPrev  <= 1'b1;
        end else begin
            r_rxSync1 <= RX;
            r_rxSync2 <= r_rxSync1;
            r_rxPrev  <= r_rxSync2;
        end
    end

    assign w_fallEdge = r_rxPrev & ~r_rxSync2;

    // ------------------------------------------------------------------
    // RX receiver
    // ------------------------------------------------------------------
    rx_state_t        r_rxState;
    rx_state_t        w_rxNext;
    logic [CNT_W-1:0] r_rxBaud;
    logic [3:0]       r_rxBitIdx;
    logic [7:0]       r_rxShift;
    logic             w_rxTick;
    logic             w_rxRdy;
    logic             r_rxRdy;

    assign w_rxTick   = (r_rxState == RX_RECV) && (r_rxBaud == '0);
    assign w_startDet = (r_rxState == RX_IDLE) && w_fallEdge;

    // Receiver state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rxState <= RX_IDLE;
        else        r_rxState <= w_rxNext;
    end

    // Receiver next state: drop glitches on the start sample, accept only a good stop bit.
    always_comb begin
        w_rxNext = r_rxState;
        w_rxRdy  = 1'b0;
        case (r_rxState)
            RX_IDLE: begin
                if (w_fallEdge) w_rxNext = RX_RECV;
            end
            RX_RECV: begin
                if (w_rxTick) begin
                    if (r_rxBitIdx == 4'd0 && r_rxSync2) begin
                        w_rxNext = RX_IDLE;
                    end else if (r_rxBitIdx == 4'd9) begin
                        w_rxNext = RX_IDLE;
                        w_rxRdy  = r_rxSync2;
                    end
                end
            end
            default: w_rxNext = RX_IDLE;
        endcase
    end

    // Baud timing and data capture: first sample is mid start bit, then one per bit time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxBaud   <= '0;
            r_rxBitIdx <= '0;
            r_rxShift  <= '0;
            r_rxRdy    <= 1'b0;
        end else begin
            r_rxRdy <= w_rxRdy;
            if (w_startDet) begin
                r_rxBaud   <= BAUD_HALF;
                r_rxBitIdx <= '0;
            end else if (r_rxState == RX_RECV) begin
                if (w_rxTick) begin
                    r_rxBaud   <= BAUD_FULL;
                    r_rxBitIdx <= r_rxBitIdx + 4'd1;
                    if (r_rxBitIdx >= 4'd1 && r_rxBitIdx <= 4'd8) begin
                        r_rxShift <= {r_rxSync2, r_rxShift[7:1]};
                    end
                end else begin
                    r_rxBaud <= r_rxBaud - CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Command assembly
    // ------------------------------------------------------------------
    asm_state_t r_asmState;
    asm_state_t w_asmNext;
    logic [7:0] r_highByte;
    logic       w_tmoExpire;

`ifdef CMD_TIMEOUT_EN
    localparam int TMO_LIMIT = TMO_BITS * BAUD_DIV;
    localparam int TMO_W     = $clog2(TMO_LIMIT);
    logic [TMO_W-1:0] r_tmoCnt;

    // Timeout counter sits at zero in HIGH, so it restarts every time LOW is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      r_tmoCnt <= '0;
        else if (r_asmState == ASM_HIGH) r_tmoCnt <= '0;
        else                             r_tmoCnt <= r_tmoCnt + TMO_W'(1);
    end

    assign w_tmoExpire = (r_asmState == ASM_LOW) && (r_tmoCnt == TMO_W'(TMO_LIMIT - 1));
`else
    // Without the timeout, LOW waits indefinitely for the low byte.
    assign w_tmoExpire = (TMO_BITS < 0);
`endif

    // Assembly state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_asmState <= ASM_HIGH;
        else        r_asmState <= w_asmNext;
    end

    // Assembly next state: alternate high/low bytes, with an optional bail-out from LOW.
    always_comb begin
        w_asmNext = r_asmState;
        case (r_asmState)
            ASM_HIGH: begin
                if (r_rxRdy) w_asmNext = ASM_LOW;
            end
            ASM_LOW: begin
                if (r_rxRdy)          w_asmNext = ASM_HIGH;
                else if (w_tmoExpire) w_asmNext = ASM_HIGH;
            end
            default: w_asmNext = ASM_HIGH;
        endcase
    end

    // Hold the first byte of a command until its partner arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 r_highByte <= '0;
        else if (r_asmState == ASM_HIGH && r_rxRdy) r_highByte <= r_rxShift;
    end

    // Publish the command; setting cmd_rdy takes priority over any clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd     <= '0;
            cmd_rdy <= 1'b0;
        end else if (r_asmState == ASM_LOW && r_rxRdy) begin
            cmd     <= {r_highByte, r_rxShift};
            cmd_rdy <= 1'b1;
        end else if (clr_cmd_rdy || (r_asmState == ASM_HIGH && w_startDet)) begin
            cmd_rdy <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // TX transmitter
    // ------------------------------------------------------------------
    tx_state_t        r_txState;
    tx_state_t        w_txNext;
    logic [CNT_W-1:0] r_txBaud;
    logic [3:0]       r_txBitIdx;
    logic [9:0]       r_txShift;
    logic             w_txTick;

    assign w_txTick = (r_txState == TX_XMIT) && (r_txBaud == '0);
    assign TX       = r_txShift[0];

    // Transmitter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_txState <= TX_IDLE;
        else        r_txState <= w_txNext;
    end

    // Transmitter next state: start on trmt from idle, finish after the tenth bit period.
    always_comb begin
        w_txNext = r_txState;
        case (r_txState)
            TX_IDLE: begin
                if (trmt) w_txNext = TX_XMIT;
            end
            TX_XMIT: begin
                if (w_txTick && r_txBitIdx == 4'd9) w_txNext = TX_IDLE;
            end
            default: w_txNext = TX_IDLE;
        endcase
    end

    // Frame shifter: ones fill in behind the data, so the line rests high when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txShift  <= '1;
            r_txBaud   <= '0;
            r_txBitIdx <= '0;
            tx_done    <= 1'b0;
        end else if (r_txState == TX_IDLE) begin
            if (trmt) begin
                r_txShift  <= {1'b1, resp, 1'b0};
                r_txBaud   <= BAUD_FULL;
                r_txBitIdx <= '0;
                tx_done    <= 1'b0;
            end
        end else begin
            if (w_txTick) begin
                r_txShift  <= {1'b1, r_txShift[9:1]};
                r_txBaud   <= BAUD_FULL;
                r_txBitIdx <= r_txBitIdx + 4'd1;
                if (r_txBitIdx == 4'd9) tx_done <= 1'b1;
            end else begin
                r_txBaud <= r_txBaud - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cmd_link.sv
// tb_cmd_link: directed bench for cmd_link using a short bit period.
module tb_cmd_link;

    localparam int BAUD = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        trmt;
    logic        tx_done;

    int passCnt = 0;
    int totalCnt = 0;
    int rdyRises = 0;
    logic prevRdy = 1'b0;
    logic dummy;

    cmd_link #(.BAUD_DIV(BAUD), .TMO_BITS(40)) dut (
        .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd),
        .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .resp(resp),
        .trmt(trmt), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    // Count rising edges of cmd_rdy.
    always @(negedge clk) begin
        if (cmd_rdy === 1'b1 && prevRdy === 1'b0) rdyRises = rdyRises + 1;
        prevRdy = cmd_rdy;
    end

    // Remote-unit style UART frame driver; reports cmd_rdy halfway through the start bit.
    task automatic send_byte(input logic [7:0] b, input logic stopBit, output logic rdyInStart);
        @(negedge clk);
        RX = 1'b0;
        repeat (BAUD / 2) @(negedge clk);
        rdyInStart = cmd_rdy;
        repeat (BAUD - BAUD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BAUD) @(negedge clk);
        end
        RX = stopBit;
        repeat (BAUD) @(negedge clk);
        RX = 1'b1;
        repeat (BAUD) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; RX = 1'b1; trmt = 1'b0; clr_cmd_rdy = 1'b0; resp = 8'h00;
        repeat (3) @(negedge clk);
        totalCnt++; if (TX !== 1'b1) $display("[TB] FAIL reset_TX: got %b expected 1", TX); else passCnt++;
        totalCnt++; if (cmd !== 16'h0000) $display("[TB] FAIL reset_cmd: got %h expected 0000", cmd); else passCnt++;
        totalCnt++; if (cmd_rdy !== 1'b0) $display("[TB] FAIL reset_cmd_rdy: got %b expected 0", cmd_rdy); else passCnt++;
        totalCnt++; if (tx_done !== 1'b0) $display("[TB] FAIL reset_tx_done: got %b expected 0", tx_done); else passCnt++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_command();
        int base;
        logic seen;
        base = rdyRises;
        send_byte(8'h2A, 1'b1, dummy);
        totalCnt++; if (cmd_rdy !== 1'b0) $display("[TB] FAIL cmd_rdy_after_high: got %b expected 0", cmd_rdy); else passCnt++;
        send_byte(8'h5C, 1'b1, dummy);
        seen = 1'b0;
        for (int i = 0; i < 4 * BAUD && !seen; i++) begin
            if (cmd_rdy === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        totalCnt++; if (seen !== 1'b1) $display("[TB] FAIL cmd_rdy_wait: got %b expected 1 (timeout)", seen); else passCnt++;
        totalCnt++; if (cmd !== 16'h2A5C) $display("[TB] FAIL cmd_2A5C: got %h expected 2a5c", cmd); else passCnt++;
        repeat (2 * BAUD) @(negedge clk);
        totalCnt++; if (rdyRises - base !== 1) $display("[TB] FAIL cmd_rdy_rises: got %0d expected 1", rdyRises - base); else passCnt++;
        @(negedge clk); clr_cmd_rdy = 1'b1;
        @(negedge clk); clr_cmd_rdy = 1'b0;
        totalCnt++; if (cmd_rdy !== 1'b0) $display("[TB] FAIL clr_cmd_rdy: got %b expected 0", cmd_rdy); else passCnt++;
        totalCnt++; if (cmd !== 16'h2A5C) $display("[TB] FAIL cmd_hold: got %h expected 2a5c", cmd); else passCnt++;
    endtask

    task automatic test_transmit();
        logic [9:0] expBits;
        logic [7:0] rcvByte;
        logic       first, last, doneEarly;
        expBits = {1'b1, 8'hA5, 1'b0};
        rcvByte = 8'h00;
        doneEarly = 1'b0;
        resp = 8'hA5;
        @(negedge clk); trmt = 1'b1;
        @(negedge clk); trmt = 1'b0; resp = 8'h00;
        for (int k = 0; k < 10; k++) begin
            first = TX;
            if (k == 1) begin trmt = 1'b1; resp = 8'hFF; end
            @(negedge clk);
            trmt = 1'b0;
            repeat (BAUD - 2) @(negedge clk);
            last = TX;
            if (k == 9) doneEarly = tx_done;
            @(negedge clk);
            if (k >= 1 && k <= 8) rcvByte[k-1] = first;
            totalCnt++;
            if (first !== expBits[k] || last !== expBits[k])
                $display("[TB] FAIL tx_bit%0d: got start=%b end=%b expected %b", k, first, last, expBits[k]);
            else passCnt++;
        end
        totalCnt++; if (doneEarly !== 1'b0) $display("[TB] FAIL tx_done_early: got %b expected 0", doneEarly); else passCnt++;
        totalCnt++; if (tx_done !== 1'b1) $display("[TB] FAIL tx_done_set: got %b expected 1", tx_done); else passCnt++;
        totalCnt++; if (TX !== 1'b1) $display("[TB] FAIL tx_idle: got %b expected 1", TX); else passCnt++;
        totalCnt++; if (rcvByte !== 8'hA5) $display("[TB] FAIL tx_resp_byte: got %h expected a5", rcvByte); else passCnt++;
        resp = 8'h3C;
        @(negedge clk); trmt = 1'b1;
        @(negedge clk); trmt = 1'b0;
        totalCnt++; if (tx_done !== 1'b0) $display("[TB] FAIL tx_done_clear: got %b expected 0", tx_done); else passCnt++;
        repeat (10 * BAUD + 2) @(negedge clk);
        totalCnt++; if (tx_done !== 1'b1) $display("[TB] FAIL tx_done_second: got %b expected 1", tx_done); else passCnt++;
    endtask

    task automatic test_back_to_back();
        logic rdyStart;
        send_byte(8'h12, 1'b1, dummy);
        send_byte(8'h34, 1'b1, dummy);
        totalCnt++; if (cmd !== 16'h1234) $display("[TB] FAIL b2b_cmd_1234: got %h expected 1234", cmd); else passCnt++;
        totalCnt++; if (cmd_rdy !== 1'b1) $display("[TB] FAIL b2b_rdy_first: got %b expected 1", cmd_rdy); else passCnt++;
        send_byte(8'hF0, 1'b1, rdyStart);
        totalCnt++; if (rdyStart !== 1'b0) $display("[TB] FAIL b2b_rdy_fall: got %b expected 0", rdyStart); else passCnt++;
        totalCnt++; if (cmd !== 16'h1234) $display("[TB] FAIL b2b_cmd_hold: got %h expected 1234", cmd); else passCnt++;
        send_byte(8'h0F, 1'b1, dummy);
        totalCnt++; if (cmd !== 16'hF00F) $display("[TB] FAIL b2b_cmd_F00F: got %h expected f00f", cmd); else passCnt++;
        totalCnt++; if (cmd_rdy !== 1'b1) $display("[TB] FAIL b2b_rdy_second: got %b expected 1", cmd_rdy); else passCnt++;
    endtask

    task automatic test_framing();
        send_byte(8'h12, 1'b1, dummy);
        send_byte(8'h99, 1'b0, dummy);
        totalCnt++; if (cmd_rdy !== 1'b0) $display("[TB] FAIL frame_bad_rdy: got %b expected 0", cmd_rdy); else passCnt++;
        totalCnt++; if (cmd !== 16'hF00F) $display("[TB] FAIL frame_bad_cmd: got %h expected f00f", cmd); else passCnt++;
        send_byte(8'h56, 1'b1, dummy);
        totalCnt++; if (cmd !== 16'h1256) $display("[TB] FAIL frame_cmd_1256: got %h expected 1256", cmd); else passCnt++;
        totalCnt++; if (cmd_rdy !== 1'b1) $display("[TB] FAIL frame_rdy_1256: got %b expected 1", cmd_rdy); else passCnt++;
        send_byte(8'h78, 1'b1, dummy);
        totalCnt++; if (cmd !== 16'h1256) $display("[TB] FAIL frame_pending_cmd: got %h expected 1256", cmd); else passCnt++;
        totalCnt++; if (cmd_rdy !== 1'b0) $display("[TB] FAIL frame_pending_rdy: got %b expected 0", cmd_rdy); else passCnt++;
        send_byte(8'h9A, 1'b1, dummy);
        totalCnt++; if (cmd !== 16'h789A) $display("[TB] FAIL frame_cmd_789A: got %h expected 789a", cmd); else passCnt++;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        b = 8'hAB;
        resp = 8'h00;
        @(negedge clk); trmt = 1'b1;
        @(negedge clk); trmt = 1'b0;
        RX = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RX = b[i];
            repeat (BAUD) @(negedge clk);
        end
        RX = b[4];
        repeat (BAUD / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        totalCnt++; if (TX !== 1'b1) $display("[TB] FAIL midrst_TX: got %b expected 1", TX); else passCnt++;
        totalCnt++; if (cmd !== 16'h0000) $display("[TB] FAIL midrst_cmd: got %h expected 0000", cmd); else passCnt++;
        totalCnt++; if (cmd_rdy !== 1'b0) $display("[TB] FAIL midrst_cmd_rdy: got %b expected 0", cmd_rdy); else passCnt++;
        totalCnt++; if (tx_done !== 1'b0) $display("[TB] FAIL midrst_tx_done: got %b expected 0", tx_done); else passCnt++;
        repeat (3) @(negedge clk);
        RX = 1'b1;
        rst_n = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
        totalCnt++; if (TX !== 1'b1) $display("[TB] FAIL midrst_TX_after: got %b expected 1", TX); else passCnt++;
        send_byte(8'hBE, 1'b1, dummy);
        send_byte(8'hEF, 1'b1, dummy);
        totalCnt++; if (cmd !== 16'hBEEF) $display("[TB] FAIL midrst_cmd_BEEF: got %h expected beef", cmd); else passCnt++;
        totalCnt++; if (cmd_rdy !== 1'b1) $display("[TB] FAIL midrst_rdy_BEEF: got %b expected 1", cmd_rdy); else passCnt++;
    endtask

    task automatic test_glitch();
        @(negedge clk); RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
        totalCnt++; if (cmd !== 16'hBEEF) $display("[TB] FAIL glitch_cmd: got %h expected beef", cmd); else passCnt++;
        send_byte(8'hC3, 1'b1, dummy);
        send_byte(8'h3C, 1'b1, dummy);
        totalCnt++; if (cmd !== 16'hC33C) $display("[TB] FAIL glitch_cmd_C33C: got %h expected c33c", cmd); else passCnt++;
    endtask

    task automatic test_timeout();
        logic [15:0] expCmd;
        logic        expRdy;
`ifdef CMD_TIMEOUT_EN
        expCmd = 16'h2233; expRdy = 1'b1;
`else
        expCmd = 16'h1122; expRdy = 1'b0;
`endif
        send_byte(8'h11, 1'b1, dummy);
        repeat (50 * BAUD) @(negedge clk);
        send_byte(8'h22, 1'b1, dummy);
        send_byte(8'h33, 1'b1, dummy);
        totalCnt++; if (cmd !== expCmd) $display("[TB] FAIL timeout_cmd: got %h expected %h", cmd, expCmd); else passCnt++;
        totalCnt++; if (cmd_rdy !== expRdy) $display("[TB] FAIL timeout_rdy: got %b expected %b", cmd_rdy, expRdy); else passCnt++;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_command();
        test_transmit();
        test_back_to_back();
        test_framing();
        test_reset_midframe();
        test_glitch();
        test_timeout();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/cmd_link.md
Name: cmd_link

Overview:
- Robot-side end of the remote command link; counterpart of the remote unit, which sends 16-bit commands as two UART bytes and waits for a one-byte response.
- Deserializes RX into bytes and assembles two bytes into cmd with a sticky cmd_rdy flag for the command processor.
- Serializes resp onto TX when trmt is pulsed.
- Sits between the top-level RX/TX pins and the command/tour logic.

Parameters:
- BAUD_DIV, 2604: clk cycles per UART bit (50 MHz / 19200 baud); minimum 16.
- TMO_BITS, 40: bit times allowed between high and low byte; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- RX  in  1  serial in from remote unit, idle high, asynchronous to clk
- TX  out  1  serial out to remote unit, idle high
- cmd  out  16  assembled command, {first byte, second byte}
- cmd_rdy  out  1  sticky flag, high while a complete command is held in cmd
- clr_cmd_rdy  in  1  one-cycle pulse from consumer that clears cmd_rdy
- resp  in  8  response byte, sampled on trmt
- trmt  in  1  one-cycle pulse that starts a response transmission
- tx_done  out  1  sticky flag, set when the stop bit completes, cleared on next trmt

Behaviour:
- Reset values: TX=1, cmd=0, cmd_rdy=0, tx_done=0. Both synchronizer flops preset to 1. All FSMs go to IDLE/HIGH.
- Frame format: 8N1, LSB first. One start bit (0), 8 data bits, one stop bit (1).
- RX path:
  - RX passes through a 2-flop synchronizer.
  - IDLE -> RECV on a synchronized falling edge.
  - The baud counter loads BAUD_DIV/2 for the first sample point (mid start bit), then BAUD_DIV for each following sample.
  - 10 samples are taken in total: start, 8 data, stop. The shift register captures the 8 data samples.
  - After the stop sample, return to IDLE. rx_rdy (internal) pulses 1 cycle only if stop=1; a stop of 0 (framing error) discards the byte.
  - A start sample reading 1 is treated as a glitch: return to IDLE, no byte.
- Assembly FSM (states HIGH, LOW):
  - HIGH + rx_rdy: store the byte as the high byte, go to LOW.
  - LOW + rx_rdy: cmd <= {high, byte}, cmd_rdy <= 1, go to HIGH.
  - cmd changes only at that assembly cycle.
  - cmd_rdy clears on clr_cmd_rdy, or on detection of a start edge while in HIGH (a new command is beginning).
  - If set and clear occur in the same cycle, set wins.
  - Latency: cmd_rdy rises 1 clk after the rx_rdy for the low byte, which is about 1.5 sync + 9.5 bit times after that byte's start edge.
- TX path (states IDLE, XMIT):
  - trmt in IDLE: load {1, resp, 0} into a 10-bit shifter, clear tx_done, enter XMIT. TX drives the shifter LSB.
  - Shift every BAUD_DIV clks. After 10 bit periods, go to IDLE, set tx_done, TX=1.
  - trmt during XMIT is ignored.
  - The TX and RX paths are fully independent; full duplex is allowed.
- Reset asserted mid-frame aborts immediately to the reset values. A partially assembled high byte is lost.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- When defined:
  - A counter runs in the LOW state.
  - If no rx_rdy arrives within TMO_BITS*BAUD_DIV clks of entering LOW, the FSM returns to HIGH, discards the high byte, and leaves cmd/cmd_rdy untouched.
  - The counter resets on entering LOW.
- When undefined: LOW waits indefinitely, and no counter logic is synthesized.

Test Plan:
- Remote unit sends 0x2A5C -> cmd_rdy rises once, cmd=16'h2A5C; clr_cmd_rdy pulse -> cmd_rdy=0 on the next clk; cmd holds 0x2A5C.
- resp=8'hA5, trmt pulse -> TX bit sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly BAUD_DIV clks; tx_done=1 after 10*BAUD_DIV clks; remote unit resp_rdy with resp=0xA5.
- Two back-to-back commands 0x1234 then 0xF00F without clearing -> cmd_rdy falls at the 0xF0 start edge, then rises with cmd=0xF00F.
- Low byte sent with stop bit forced 0, then valid bytes 0x56, 0x78 -> no cmd_rdy on the bad frame; final cmd=0x1256 (the pending high byte 0x12 pairs with 0x56), and 0x78 waits as the next high byte.
- rst_n asserted during bit 4 of the high byte, released, then 0xBEEF sent -> outputs at reset values during reset; cmd=0xBEEF afterward.
- CMD_TIMEOUT_EN defined: send 0x11, idle for 50 bit times, send 0x22, 0x33 -> cmd=0x2233. Undefined: cmd=0x1122.
